piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Read side of the team's flip-flop storage path: accepts a parallel word from a register bank
//  via valid/ready and shifts it out one bit per enabled clock on a serial line with complement.
//  Sits between word-wide storage and any bit-serial consumer; gives one-cycle done per frame.
// PARAMETERS
//  WIDTH      8  data word width in bits (>=2)
//  MSB_FIRST  1  1: bit WIDTH-1 sent first; 0: bit 0 sent first
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  reset        in   1      synchronous, active-high reset
//  load_valid   in   1      load_data valid
//  load_ready   out  1      block can accept a word (IDLE only)
//  load_data    in   WIDTH  parallel word to serialize
//  ser_enable   in   1      consumer takes current bit this cycle; low = stall
//  ser_out      out  1      current serial bit
//  ser_out_n    out  1      always ~ser_out
//  ser_valid    out  1      ser_out carries a frame bit
//  frame_start  out  1      high while first data bit is presented
//  done         out  1      one-cycle pulse after final bit consumed
// BEHAVIOUR
//  - Reset (sync, high): state IDLE, shift reg/counter 0; ser_out 0, ser_out_n 1, ser_valid 0,
//    frame_start 0, done 0, load_ready 1. Reset mid-frame aborts it; no done is issued.
//  - FSM states: IDLE, SHIFT, PAR (PAR exists only with PARITY_EN).
//  - IDLE: load_ready=1; load_valid&&load_ready at posedge captures load_data, counter=0,
//    -> SHIFT. ser_enable ignored. ser_out=0, ser_valid=0.
//  - SHIFT: ser_valid=1, ser_out=current bit (MSB or LSB end of shift reg per MSB_FIRST),
//    driven from registers (no combinational path from inputs). frame_start=1 iff counter==0.
//    ser_enable=1: shift reg advances one bit, counter+1. ser_enable=0: all state and outputs hold.
//    Bit consumed with counter==WIDTH-1: -> IDLE (or PAR with PARITY_EN).
//  - Latency: first bit presented the cycle after acceptance; min frame = WIDTH cycles + 1 IDLE.
//  - done: registered, high exactly the first IDLE cycle after a frame; load_ready is 1 that same
//    cycle, so a word may be accepted then (back-to-back frames, one-cycle gap).
//  - load_valid while not IDLE: ignored, load_ready=0, data not captured, frame unaffected.
//  - Counter width $clog2(WIDTH)+1; never wraps within a frame.
// CONFIGURATION
//  PARITY_EN defined: even parity over the WIDTH data bits, computed at load, sent as one extra
//   bit in PAR (ser_valid=1, frame_start=0); consumed on ser_enable like data; stalls likewise;
//   then -> IDLE with done. Frame = WIDTH+1 bits.
//  PARITY_EN undefined: no PAR state or parity logic; SHIFT goes directly to IDLE.
// TESTING
//  1. WIDTH=8,MSB_FIRST=1, load 0xA5, ser_enable=1 -> ser_out 1,0,1,0,0,1,0,1 on cycles 1-8,
//     frame_start cycle 1 only, done+load_ready cycle 9.
//  2. MSB_FIRST=0, load 0x01, ser_enable=1 -> ser_out 1 then seven 0s; ser_out_n inverse every cycle.
//  3. 0xA5, drop ser_enable 3 cycles while bit 2 presented -> bit 2 held 4 cycles; done cycle 12.
//  4. Load 0x3C, assert load_valid with 0xFF during bit 3 -> load_ready=0, serial stream still 0x3C.
//  5. Assert reset during bit 4 -> next cycle ser_valid=0, ser_out=0, load_ready=1, no done pulse.
//  6. PARITY_EN: 0xA5 -> 9th bit 0, done cycle 10; 0x07 -> 9th bit 1; done asserted exactly once.

Source files
------------

// File: rtl/piso_serializer_if.sv
//------------------------------------------------------------------------------
// Module : piso_serializer_if
// Brief  : Load handshake and serial output bundle for piso_serializer.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_enable;
  logic             ser_out;
  logic             ser_out_n;
  logic             ser_valid;
  logic             frame_start;
  logic             done;

  modport master (
    output load_valid, load_data, ser_enable,
    input  load_ready, ser_out, ser_out_n, ser_valid, frame_start, done
  );

  modport slave (
    input  load_valid, load_data, ser_enable,
    output load_ready, ser_out, ser_out_n, ser_valid, frame_start, done
  );
endinterface

`default_nettype wire

// File: rtl/piso_serializer.sv
//------------------------------------------------------------------------------
// Module : piso_serializer
// Brief  : Parallel-in serial-out shifter with valid/ready load and done pulse.
//          Define PARITY_EN to append an even-parity bit to every frame.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic        clk,
  input  wire logic        reset,
  piso_serializer_if.slave bus
);

  localparam int              CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
`ifdef PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             cur_bit;
  logic [WIDTH-1:0] shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign cur_bit = shift_q[WIDTH-1];
      assign shifted = {shift_q[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign cur_bit = shift_q[0];
      assign shifted = {1'b0, shift_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
`ifdef PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
`ifdef PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
`ifdef PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          shift_d  = bus.load_data;
          cnt_d    = '0;
          state_d  = SHIFT;
`ifdef PARITY_EN
          parity_d = ^bus.load_data;
`endif
        end
      end
      SHIFT: begin
        if (bus.ser_enable) begin
          shift_d = shifted;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
`ifdef PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef PARITY_EN
      PAR: begin
        if (bus.ser_enable) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Serial outputs are decoded from flops only; ser_enable never reaches them.
  always_comb begin
    bus.ser_out = 1'b0;
    case (state_q)
      SHIFT:   bus.ser_out = cur_bit;
`ifdef PARITY_EN
      PAR:     bus.ser_out = parity_q;
`endif
      default: bus.ser_out = 1'b0;
    endcase
  end

  assign bus.ser_out_n   = ~bus.ser_out;
  assign bus.ser_valid   = (state_q != IDLE);
  assign bus.load_ready  = (state_q == IDLE);
  assign bus.frame_start = (state_q == SHIFT) && (cnt_q == '0);
  assign bus.done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
//------------------------------------------------------------------------------
// Module : tb_piso_serializer
// Brief  : Directed bench for piso_serializer, MSB-first and LSB-first instances.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_piso_serializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(8)) m_if ();
  piso_serializer_if #(.WIDTH(8)) l_if ();

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .reset(reset), .bus(m_if));
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .reset(reset), .bus(l_if));

  typedef struct {
    bit         sel;   // 0: MSB-first instance, 1: LSB-first instance
    logic [7:0] data;
    logic [7:0] seq;   // expected bits in transmit order, first bit at [7]
    logic       par;
  } vec_t;

  vec_t vt[8];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic e);
    m_if.load_valid = v; m_if.load_data = d; m_if.ser_enable = e;
    l_if.load_valid = v; l_if.load_data = d; l_if.ser_enable = e;
  endtask

  // {load_ready, ser_out, ser_out_n, ser_valid, frame_start, done}
  function automatic logic [5:0] ex(input logic lr, input logic so, input logic sv,
                                    input logic fs, input logic dn);
    return {lr, so, ~so, sv, fs, dn};
  endfunction

  task automatic chk(input bit sel, input string name, input logic [5:0] exp);
    logic [5:0] act;
    if (sel) act = {l_if.load_ready, l_if.ser_out, l_if.ser_out_n,
                    l_if.ser_valid, l_if.frame_start, l_if.done};
    else     act = {m_if.load_ready, m_if.ser_out, m_if.ser_out_n,
                    m_if.ser_valid, m_if.frame_start, m_if.done};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst=%0d rdy/so/son/sv/fs/done got=%b want=%b", name, sel, act, exp);
    end
  endtask

  // Loads at the current cycle (idle or done cycle); returns in the done cycle.
  task automatic run_frame(input bit sel, input logic [7:0] data,
                           input logic [7:0] seq, input logic par);
    drive(1'b1, data, 1'b1);
    tick;
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk(sel, $sformatf("d%02h_bit%0d", data, i), ex(1'b0, seq[7-i], 1'b1, i == 0, 1'b0));
      tick;
    end
`ifdef PARITY_EN
    chk(sel, $sformatf("d%02h_par", data), ex(1'b0, par, 1'b1, 1'b0, 1'b0));
    tick;
`endif
    chk(sel, $sformatf("d%02h_done", data), ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  initial begin
    logic [7:0] seq;
    int         idx;

    vt[0] = '{1'b0, 8'hA5, 8'hA5, 1'b0};
    vt[1] = '{1'b1, 8'h01, 8'h80, 1'b1};
    vt[2] = '{1'b0, 8'h3C, 8'h3C, 1'b0};
    vt[3] = '{1'b1, 8'hA5, 8'hA5, 1'b0};
    vt[4] = '{1'b1, 8'h0E, 8'h70, 1'b1};
    vt[5] = '{1'b0, 8'h07, 8'h07, 1'b1};
    vt[6] = '{1'b0, 8'hFF, 8'hFF, 1'b0};
    vt[7] = '{1'b1, 8'h80, 8'h01, 1'b1};

    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick;
    tick;
    chk(1'b0, "reset_msb", ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    chk(1'b1, "reset_lsb", ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    tick;
    chk(1'b0, "idle_enable_ignored", ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    // Table frames run back-to-back: each loads in the previous frame's done cycle.
    for (int v = 0; v < 8; v++) run_frame(vt[v].sel, vt[v].data, vt[v].seq, vt[v].par);
    tick;
    chk(1'b0, "done_single_pulse", ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    chk(1'b1, "done_single_pulse_lsb", ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    // Stall: ser_enable low for three cycles while bit 2 is presented.
    seq = 8'hA5;
    drive(1'b1, 8'hA5, 1'b1);
    tick;
    drive(1'b0, 8'h00, 1'b1);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      idx = (cyc <= 3) ? cyc - 1 : (cyc <= 6) ? 2 : cyc - 4;
      chk(1'b0, $sformatf("stall_c%0d", cyc), ex(1'b0, seq[7-idx], 1'b1, cyc == 1, 1'b0));
      drive(1'b0, 8'h00, (cyc >= 3 && cyc <= 5) ? 1'b0 : 1'b1);
      tick;
    end
`ifdef PARITY_EN
    chk(1'b0, "stall_par", ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick;
`endif
    chk(1'b0, "stall_done", ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tick;

    // load_valid with 0xFF during bit 3 must not disturb the 0x3C frame.
    seq = 8'h3C;
    drive(1'b1, 8'h3C, 1'b1);
    tick;
    drive(1'b0, 8'h00, 1'b1);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc == 4 || cyc == 5) drive(1'b1, 8'hFF, 1'b1);
      chk(1'b0, $sformatf("busy_c%0d", cyc), ex(1'b0, seq[8-cyc], 1'b1, cyc == 1, 1'b0));
      tick;
      drive(1'b0, 8'h00, 1'b1);
    end
`ifdef PARITY_EN
    chk(1'b0, "busy_par", ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    tick;
`endif
    chk(1'b0, "busy_done", ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    tick;

    // Reset while bit 4 is presented aborts the frame with no done.
    seq = 8'hA5;
    drive(1'b1, 8'hA5, 1'b1);
    tick;
    drive(1'b0, 8'h00, 1'b1);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      chk(1'b0, $sformatf("abort_c%0d", cyc), ex(1'b0, seq[8-cyc], 1'b1, cyc == 1, 1'b0));
      if (cyc < 5) tick;
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk(1'b0, "abort_reset_msb", ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    chk(1'b1, "abort_reset_lsb", ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick;
      chk(1'b0, $sformatf("abort_nodone_%0d", cyc), ex(1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
